// File: rtl/tsc_pkg.sv
// Shared types and constants for the 16-bit TSC CPU: widths, fetch FSM states,
// PC/request-address mux selects and the primary opcode field encodings.
package tsc_pkg;

  localparam int WORD_SIZE = 16;
  localparam int TARGET_W  = 12;
  localparam int OPCODE_W  = 4;
  localparam int FUNC_W    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_KEEP = 2'd0,
    PC_TGT  = 2'd1,
    PC_NEXT = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    REQ_KEEP = 2'd0,
    REQ_PC   = 2'd1,
    REQ_TGT  = 2'd2
  } req_sel_e;

  typedef enum logic [OPCODE_W-1:0] {
    OP_BNE = 4'd0,
    OP_BEQ = 4'd1,
    OP_BGZ = 4'd2,
    OP_BLZ = 4'd3,
    OP_ADI = 4'd4,
    OP_ORI = 4'd5,
    OP_LHI = 4'd6,
    OP_LWD = 4'd7,
    OP_SWD = 4'd8,
    OP_JMP = 4'd9,
    OP_JAL = 4'd10,
    OP_ALU = 4'd15
  } opcode_e;

  typedef enum logic [FUNC_W-1:0] {
    FN_ADD = 6'd0,
    FN_SUB = 6'd1,
    FN_AND = 6'd2,
    FN_ORR = 6'd3,
    FN_NOT = 6'd4,
    FN_TCP = 6'd5,
    FN_SHL = 6'd6,
    FN_SHR = 6'd7,
    FN_WWD = 6'd28,
    FN_JPR = 6'd25,
    FN_JRL = 6'd26,
    FN_HLT = 6'd29
  } alu_func_e;

  // Jumps stay inside the current 4K page: the upper nibble never changes.
  function automatic logic [WORD_SIZE-1:0] redirect_pc(
    input logic [WORD_SIZE-1:0] pc,
    input logic [TARGET_W-1:0]  target
  );
    return {pc[WORD_SIZE-1:TARGET_W], target};
  endfunction

  function automatic logic [OPCODE_W-1:0] inst_opcode(input logic [WORD_SIZE-1:0] inst);
    return inst[WORD_SIZE-1:WORD_SIZE-OPCODE_W];
  endfunction

  function automatic logic [TARGET_W-1:0] inst_target(input logic [WORD_SIZE-1:0] inst);
    return inst[TARGET_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter and outstanding-read address registers with their
// increment / redirect muxing; the fetch FSM picks the update each cycle.
module fetch_pc_reg
  import tsc_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           pc_sel_i,
  input  logic [1:0]           req_sel_i,
  input  logic [TARGET_W-1:0]  redirect_target_i,
  output logic [WORD_SIZE-1:0] req_addr_o
);

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] req_q, req_d;
  logic [WORD_SIZE-1:0] tgt;

  assign tgt        = redirect_pc(pc_q, redirect_target_i);
  assign req_addr_o = req_q;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel_e'(pc_sel_i))
      PC_TGT:  pc_d = tgt;
      PC_NEXT: pc_d = req_q + WORD_SIZE'(1);
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    req_d = req_q;
    case (req_sel_e'(req_sel_i))
      REQ_PC:  req_d = pc_q;
      REQ_TGT: req_d = tgt;
      default: req_d = req_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      req_q <= RESET_PC;
    end else begin
      pc_q  <= pc_d;
      req_q <= req_d;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: drives the readM/inputReady memory handshake, holds one
// instruction for decode under valid/ready, and absorbs jump redirects.
module inst_fetch_unit
  import tsc_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [WORD_SIZE-1:0] inst_pc,
  input  logic                 redirect,
  input  logic [TARGET_W-1:0]  redirect_target,
  output logic [WORD_SIZE-1:0] num_inst
);

  fetch_state_e         state_q;
  logic [WORD_SIZE-1:0] inst_q;
  logic [WORD_SIZE-1:0] inst_pc_q;
  logic [WORD_SIZE-1:0] num_inst_q;
  logic [WORD_SIZE-1:0] req_addr;
  logic [1:0]           pc_sel;
  logic [1:0]           req_sel;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk               (clk),
    .reset             (reset),
    .pc_sel_i          (pc_sel),
    .req_sel_i         (req_sel),
    .redirect_target_i (redirect_target),
    .req_addr_o        (req_addr)
  );

  // A redirect that lands while a read is outstanding only moves pc; the
  // request address is left alone until the memory has answered.
  always_comb begin
    pc_sel  = PC_KEEP;
    req_sel = REQ_KEEP;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_sel  = PC_TGT;
          req_sel = REQ_TGT;
        end else begin
          req_sel = REQ_PC;
        end
      end
      FETCH: begin
        if (redirect) begin
          pc_sel = PC_TGT;
          if (inputReady) req_sel = REQ_TGT;
        end else if (inputReady) begin
          pc_sel = PC_NEXT;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_sel = PC_TGT;
          if (inputReady) req_sel = REQ_TGT;
        end else if (inputReady) begin
          req_sel = REQ_PC;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_sel  = PC_TGT;
          req_sel = REQ_TGT;
        end else if (inst_ready) begin
          req_sel = REQ_PC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      num_inst_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (inputReady && !redirect) begin
            inst_q    <= data_in;
            inst_pc_q <= req_addr;
            state_q   <= HOLD;
          end else if (!inputReady && redirect) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (inputReady) state_q <= FETCH;
        end
        HOLD: begin
          if (inst_ready) num_inst_q <= num_inst_q + WORD_SIZE'(1);
          if (inst_ready || redirect) state_q <= FETCH;
        end
      endcase
    end
  end

  assign readM      = (state_q == FETCH) || (state_q == DRAIN);
  assign address    = req_addr;
  assign inst_valid = (state_q == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign num_inst   = num_inst_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the fetch stage.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, readM, inputReady, inst_valid, inst_ready, redirect;
  logic [15:0] address, data_in, inst, inst_pc, num_inst;
  logic [11:0] redirect_target;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .readM           (readM),
    .address         (address),
    .data_in         (data_in),
    .inputReady      (inputReady),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_pc         (inst_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .num_inst        (num_inst)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // model: a read is in flight (m_reading), possibly to be discarded
  // (m_squash), or an instruction is parked for decode (m_hold)
  bit          m_reading, m_squash, m_hold;
  logic [15:0] m_pc, m_req, m_inst, m_ipc, m_num;

  int          cyc = 0;
  int          mem_cnt = 0;
  int          mem_lat = 2;
  bit          rnd_lat = 1'b0;
  logic        prev_readM = 1'b0;
  int          rise_t[$];
  logic [15:0] got_inst[$];
  logic [15:0] got_pc[$];
  bit          stale_seen;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("readM",      {15'b0, readM},      {15'b0, m_reading});
      check("address",    address,             m_req);
      check("inst_valid", {15'b0, inst_valid}, {15'b0, m_hold});
      check("inst",       inst,                m_inst);
      check("inst_pc",    inst_pc,             m_ipc);
      check("num_inst",   num_inst,            m_num);
    end
  end

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      16'h0002: return 16'h3333;
      default:  return 16'($urandom);
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic rd, input logic ir, input logic rdy,
                            input logic [11:0] tg, input logic [15:0] di);
    logic [15:0] tgt;
    tgt = {m_pc[15:12], tg};
    if (rst) begin
      m_reading = 0; m_squash = 0; m_hold = 0;
      m_pc = 0; m_req = 0; m_inst = 0; m_ipc = 0; m_num = 0;
    end else if (m_hold) begin
      if (rdy) m_num = m_num + 16'd1;
      if (rdy || rd) begin
        m_hold = 0;
        m_reading = 1;
        if (rd) begin
          m_pc = tgt;
          m_req = tgt;
        end else begin
          m_req = m_pc;
        end
      end
    end else if (!m_reading) begin
      if (rd) begin
        m_pc = tgt;
        m_req = tgt;
      end else begin
        m_req = m_pc;
      end
      m_reading = 1;
    end else if (m_squash) begin
      if (rd) m_pc = tgt;
      if (ir) begin
        m_squash = 0;
        m_req = m_pc;
      end
    end else begin
      if (ir && !rd) begin
        m_inst = di;
        m_ipc = m_req;
        m_pc = m_req + 16'd1;
        m_reading = 0;
        m_hold = 1;
      end else if (rd) begin
        m_pc = tgt;
        if (ir) m_req = tgt;
        else m_squash = 1;
      end
    end
  endtask

  // One clock: memory responds (mem_lat cycles after readM rises), inputs
  // are applied at the falling edge, model advances at the rising edge.
  task automatic cycle(input logic rst, input logic rd, input logic [11:0] tg,
                       input logic rdy, input logic frc);
    logic        strobe;
    logic [15:0] d;
    @(negedge clk);
    if (readM && !prev_readM) rise_t.push_back(cyc);
    prev_readM = readM;
    if (inst_valid && rdy) begin
      got_inst.push_back(inst);
      got_pc.push_back(inst_pc);
    end
    strobe = 1'b0;
    if (m_reading && !rst) begin
      mem_cnt++;
      if (mem_cnt > mem_lat) begin
        strobe = 1'b1;
        mem_cnt = 0;
        if (rnd_lat) mem_lat = $urandom_range(0, 4);
      end
    end else begin
      mem_cnt = 0;
    end
    d = mem_rd(m_req);
    reset = rst;
    redirect = rd;
    redirect_target = tg;
    inst_ready = rdy;
    inputReady = strobe | frc;
    data_in = d;
    @(posedge clk);
    model_step(rst, rd, strobe | frc, rdy, tg, d);
    cyc++;
    #2;
  endtask

  task automatic wait_hold(input string name);
    for (int i = 0; i < 60 && !inst_valid; i++) cycle(1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
    check(name, {15'b0, inst_valid}, 16'h0001);
  endtask

  task automatic consume(input int n);
    for (int i = 0; i < n; i++) begin
      wait_hold("consume_wait");
      cycle(1'b0, 1'b0, 12'h0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_target = '0;
    inst_ready = 1'b0; inputReady = 1'b0; data_in = '0;

    // basic streaming, latency 2
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk_on = 1'b1;
    check("rst_readM", {15'b0, readM}, 16'h0000);
    check("rst_valid", {15'b0, inst_valid}, 16'h0000);
    check("rst_num", num_inst, 16'h0000);
    check("rst_addr", address, 16'h0000);
    cyc = 0;
    rise_t.delete(); got_inst.delete(); got_pc.delete();
    for (int i = 0; i < 40 && got_inst.size() < 3; i++) cycle(0, 0, 0, 1, 0);
    check("t1_count", 16'(got_inst.size()), 16'd3);
    if (got_inst.size() == 3) begin
      check("t1_inst0", got_inst[0], 16'h1111);
      check("t1_inst1", got_inst[1], 16'h2222);
      check("t1_inst2", got_inst[2], 16'h3333);
      check("t1_pc0", got_pc[0], 16'h0000);
      check("t1_pc1", got_pc[1], 16'h0001);
      check("t1_pc2", got_pc[2], 16'h0002);
    end
    check("t1_num", num_inst, 16'd3);
    check("t1_rises", 16'(rise_t.size()), 16'd3);
    if (rise_t.size() >= 3) begin
      check("t1_first_rise", 16'(rise_t[0]), 16'd1);
      check("t1_gap01", 16'(rise_t[1] - rise_t[0]), 16'd4);
      check("t1_gap12", 16'(rise_t[2] - rise_t[1]), 16'd4);
    end

    // back-pressure in HOLD
    wait_hold("t2_hold");
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0);
      check("t2_valid", {15'b0, inst_valid}, 16'h0001);
      check("t2_readM", {15'b0, readM}, 16'h0000);
      check("t2_num", num_inst, 16'd3);
      check("t2_inst_pc", inst_pc, 16'h0003);
    end
    cycle(0, 0, 0, 1, 0);
    check("t2_num_rel", num_inst, 16'd4);
    check("t2_addr_rel", address, 16'h0004);

    // redirect during FETCH goes through DRAIN
    cycle(0, 1, 12'hFFF, 0, 0);
    check("t3_drain_addr", address, 16'h0004);
    wait_hold("t3_hold_fff");
    check("t3_pc_fff", inst_pc, 16'h0FFF);
    cycle(0, 0, 0, 1, 0);
    consume(3);
    check("t3_addr_1003", address, 16'h1003);
    cycle(0, 1, 12'h0A5, 0, 0);
    check("t3_readM_drain", {15'b0, readM}, 16'h0001);
    check("t3_addr_held", address, 16'h1003);
    stale_seen = 1'b0;
    for (int i = 0; i < 20 && address != 16'h10A5; i++) begin
      cycle(0, 0, 0, 0, 0);
      stale_seen |= inst_valid;
    end
    check("t3_addr_10a5", address, 16'h10A5);
    check("t3_no_stale", {15'b0, stale_seen}, 16'h0000);
    wait_hold("t3_hold_10a5");
    check("t3_pc_10a5", inst_pc, 16'h10A5);

    // redirect in HOLD with and without inst_ready
    cycle(0, 1, 12'hFFF, 0, 0);
    check("t4_num_drop", num_inst, 16'd8);
    check("t4_addr_1fff", address, 16'h1FFF);
    consume(8);
    wait_hold("t4_hold_2007");
    check("t4_pc_2007", inst_pc, 16'h2007);
    cycle(0, 1, 12'hFFF, 1, 0);
    check("t4_num_take", num_inst, 16'd17);
    check("t4_addr_2fff", address, 16'h2FFF);
    wait_hold("t4_hold_2fff");
    cycle(0, 1, 12'h123, 0, 0);
    check("t4_num_keep", num_inst, 16'd17);
    check("t4_addr_3123", address, 16'h3123);

    // walk to 0xFFFF, then wrap pc and num_inst
    for (int k = 0; k < 40 && !(inst_valid && inst_pc == 16'hFFFF); k++) begin
      wait_hold("t5_hold");
      if (inst_pc != 16'hFFFF) begin
        if (inst_pc[11:0] == 12'hFFF) cycle(0, 0, 0, 1, 0);
        else cycle(0, 1, 12'hFFF, 0, 0);
      end
    end
    check("t5_pc_ffff", inst_pc, 16'hFFFF);
    force dut.num_inst_q = 16'hFFFF;
    m_num = 16'hFFFF;
    #1;
    release dut.num_inst_q;
    cycle(0, 0, 0, 1, 0);
    check("t5_num_wrap", num_inst, 16'h0000);
    check("t5_addr_wrap", address, 16'h0000);

    // reset in FETCH and in DRAIN, late inputReady ignored
    cycle(1, 0, 0, 0, 0);
    check("t6_readM", {15'b0, readM}, 16'h0000);
    check("t6_valid", {15'b0, inst_valid}, 16'h0000);
    check("t6_inst", inst, 16'h0000);
    check("t6_inst_pc", inst_pc, 16'h0000);
    check("t6_num", num_inst, 16'h0000);
    check("t6_addr", address, 16'h0000);
    cycle(0, 0, 0, 0, 1);
    check("t6_restart_readM", {15'b0, readM}, 16'h0001);
    check("t6_restart_valid", {15'b0, inst_valid}, 16'h0000);
    cycle(0, 1, 12'h055, 0, 0);
    cycle(1, 0, 0, 0, 1);
    check("t6_drain_rst_readM", {15'b0, readM}, 16'h0000);
    cycle(0, 0, 0, 0, 1);
    check("t6_late_ir_addr", address, 16'h0000);
    check("t6_late_ir_valid", {15'b0, inst_valid}, 16'h0000);
    wait_hold("t6_hold");
    check("t6_inst_1111", inst, 16'h1111);
    check("t6_pc_0", inst_pc, 16'h0000);

    // random traffic
    rnd_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 5) == 0),
            12'($urandom),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
